// File: rtl/bp_me_axi_pkg.sv
// Shared types for the AXI burst expander.
// Descriptor fields are sized for the widest supported configuration.
package bp_me_axi_pkg;

  localparam int lg_axi_4k_lp = 12;
  localparam int axi_max_addr_width_lp = 64;
  localparam int axi_max_id_width_lp = 16;

  typedef enum logic [1:0] {
    e_fixed = 2'd0,
    e_incr  = 2'd1,
    e_wrap  = 2'd2,
    e_rsvd  = 2'd3
  } axi_burst_e;

  typedef struct packed {
    logic [axi_max_id_width_lp-1:0]   id;
    logic [axi_max_addr_width_lp-1:0] addr;
    axi_burst_e                       burst;
    logic [7:0]                       len;
    logic [2:0]                       size;
  } bp_axi_desc_s;

endpackage

// File: rtl/bp_me_axi_beat_calc.sv
// Per-beat address step, byte-lane mask and legality check.
// Purely combinational; illegal bursts step like INCR with no lanes.
module bp_me_axi_beat_calc
  import bp_me_axi_pkg::*;
#(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64
) (
  input  bp_axi_desc_s                  i_desc,
  input  logic [axi_addr_width_p-1:0]   i_addr,
  output logic [axi_addr_width_p-1:0]   o_next_addr,
  output logic [axi_data_width_p/8-1:0] o_mask,
  output logic                          o_err
);

  localparam int aw_lp = axi_addr_width_p;
  localparam int b_lp = axi_data_width_p / 8;
  localparam int lg_b_lp = $clog2(b_lp);

  logic [aw_lp-1:0] w_base;
  logic [aw_lp-1:0] w_nb;
  logic [aw_lp-1:0] w_al;
  logic [aw_lp-1:0] w_base_al;
  logic [aw_lp-1:0] w_dt;
  logic [aw_lp-1:0] w_lo;
  logic [aw_lp-1:0] w_inc;
  logic [aw_lp-1:0] w_span_end;
  logic [aw_lp-1:0] w_lane_lo;
  logic [aw_lp-1:0] w_lane_hi;
  logic             w_len_ok;
  logic             w_err;
  logic             w_unused_bits;

  assign w_base = i_desc.addr[aw_lp-1:0];
  assign w_nb = aw_lp'(1) << i_desc.size;
  assign w_al = (i_addr >> i_desc.size) << i_desc.size;
  assign w_base_al = (w_base >> i_desc.size) << i_desc.size;
  assign w_dt = (aw_lp'(i_desc.len) + aw_lp'(1)) << i_desc.size;
  assign w_lo = w_base & ~(w_dt - aw_lp'(1));
  assign w_inc = w_al + w_nb;
  assign w_span_end = w_base_al + (aw_lp'(i_desc.len) << i_desc.size);
  assign w_lane_lo = i_addr & aw_lp'(b_lp - 1);
  assign w_lane_hi = (w_inc - aw_lp'(1)) & aw_lp'(b_lp - 1);
  assign w_unused_bits = ^{i_desc.id, i_desc.addr};

  assign w_len_ok = (i_desc.len == 8'd1) || (i_desc.len == 8'd3)
                 || (i_desc.len == 8'd7) || (i_desc.len == 8'd15);

  // Legality: oversized beats, reserved burst, bad WRAP, long FIXED, 4KB cross.
  always_comb begin
    w_err = 1'b0;
    if (i_desc.size > 3'(lg_b_lp)) w_err = 1'b1;
    unique case (i_desc.burst)
      e_rsvd:  w_err = 1'b1;
      e_wrap:  if (!w_len_ok || ((w_base & (w_nb - aw_lp'(1))) != '0))
                 w_err = 1'b1;
      e_fixed: if (i_desc.len > 8'd15) w_err = 1'b1;
      e_incr:  if ((w_base_al >> lg_axi_4k_lp) != (w_span_end >> lg_axi_4k_lp))
                 w_err = 1'b1;
      default: ;
    endcase
  end

  // Next beat address by burst type.
  always_comb begin
    o_next_addr = w_inc;
    if (!w_err) begin
      unique case (i_desc.burst)
        e_fixed: o_next_addr = w_base;
        e_wrap:  if (w_inc >= (w_lo + w_dt)) o_next_addr = w_lo;
        default: ;
      endcase
    end
  end

  // Active lanes from the current address to the end of its aligned beat.
  always_comb begin
    o_mask = '0;
    for (int i = 0; i < b_lp; i++) begin
      o_mask[i] = !w_err && (aw_lp'(i) >= w_lane_lo) && (aw_lp'(i) <= w_lane_hi);
    end
  end

  assign o_err = w_err;

endmodule

// File: rtl/bp_me_axi_burst_gen.sv
// AXI burst expander: descriptor queue plus per-beat record generator.
// Beat 0 reads the head address directly so back-to-back bursts need no load cycle.
module bp_me_axi_burst_gen
  import bp_me_axi_pkg::*;
#(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64,
  parameter int axi_id_width_p   = 6,
  parameter int els_p            = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  output logic                          ready_and_o,
  input  logic [axi_id_width_p-1:0]     axid_i,
  input  logic [axi_addr_width_p-1:0]   axaddr_i,
  input  logic [1:0]                    axburst_i,
  input  logic [7:0]                    axlen_i,
  input  logic [2:0]                    axsize_i,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic [axi_id_width_p-1:0]     id_o,
  output logic [axi_addr_width_p-1:0]   addr_o,
  output logic [axi_data_width_p/8-1:0] mask_o,
  output logic [2:0]                    size_o,
  output logic [7:0]                    len_o,
  output logic [7:0]                    beat_o,
  output logic                          first_o,
  output logic                          last_o,
  output logic                          err_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  typedef enum logic {e_idle, e_busy} state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  bp_axi_desc_s                r_mem [els_p];
  logic [ptr_w_lp-1:0]         r_wptr;
  logic [ptr_w_lp-1:0]         r_rptr;
  logic [cnt_w_lp-1:0]         r_cnt;
  logic [7:0]                  r_beat;
  logic [axi_addr_width_p-1:0] r_addr;

  bp_axi_desc_s                w_in;
  bp_axi_desc_s                w_head;
  logic [axi_addr_width_p-1:0] w_addr;
  logic [axi_addr_width_p-1:0] w_next;
  logic                        w_enq;
  logic                        w_take;
  logic                        w_last;
  logic                        w_deq;

  assign w_in = '{id:    axi_max_id_width_lp'(axid_i),
                  addr:  axi_max_addr_width_lp'(axaddr_i),
                  burst: axi_burst_e'(axburst_i),
                  len:   axlen_i,
                  size:  axsize_i};

  assign w_head = r_mem[r_rptr];
  assign ready_and_o = (r_cnt != cnt_w_lp'(els_p));
  assign v_o = (r_state == e_busy);
  assign w_enq = v_i & ready_and_o;
  assign w_take = yumi_i & v_o;
  assign w_last = (r_beat == w_head.len);
  assign w_deq = w_take & w_last;
  assign w_addr = (r_beat == 8'd0) ? w_head.addr[axi_addr_width_p-1:0] : r_addr;

  bp_me_axi_beat_calc #(
    .axi_addr_width_p(axi_addr_width_p),
    .axi_data_width_p(axi_data_width_p)
  ) u_calc (
    .i_desc     (w_head),
    .i_addr     (w_addr),
    .o_next_addr(w_next),
    .o_mask     (mask_o),
    .o_err      (err_o)
  );

  // Busy while a head descriptor exists; idle when the last one drains.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      e_idle: if (w_enq) w_state_nxt = e_busy;
      e_busy: if (w_deq && !w_enq && (r_cnt == cnt_w_lp'(1)))
                w_state_nxt = e_idle;
      default: w_state_nxt = e_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_idle;
    else         r_state <= w_state_nxt;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq)
        r_wptr <= (r_wptr == ptr_w_lp'(els_p - 1)) ? '0 : r_wptr + ptr_w_lp'(1);
      if (w_deq)
        r_rptr <= (r_rptr == ptr_w_lp'(els_p - 1)) ? '0 : r_rptr + ptr_w_lp'(1);
      if (w_enq && !w_deq)      r_cnt <= r_cnt + cnt_w_lp'(1);
      else if (!w_enq && w_deq) r_cnt <= r_cnt - cnt_w_lp'(1);
    end
  end

  // Queue storage.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= w_in;
  end

  // Beat counter and running address advance on each consumed beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_beat <= '0;
    end else if (w_take) begin
      r_beat <= w_last ? 8'd0 : r_beat + 8'd1;
      r_addr <= w_next;
    end
  end

  assign id_o    = w_head.id[axi_id_width_p-1:0];
  assign addr_o  = w_addr;
  assign size_o  = w_head.size;
  assign len_o   = w_head.len;
  assign beat_o  = r_beat;
  assign first_o = (r_beat == 8'd0);
  assign last_o  = w_last;

endmodule

// File: tb/tb_bp_me_axi_burst_gen.sv
// Directed bench for bp_me_axi_burst_gen with a 64-bit data bus.
// Table of bursts with expected beats, plus queue/back-to-back/reset sequences.
module tb_bp_me_axi_burst_gen;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_and_o;
  logic [5:0]  axid_i;
  logic [63:0] axaddr_i;
  logic [1:0]  axburst_i;
  logic [7:0]  axlen_i;
  logic [2:0]  axsize_i;
  logic        v_o;
  logic        yumi_i;
  logic [5:0]  id_o;
  logic [63:0] addr_o;
  logic [7:0]  mask_o;
  logic [2:0]  size_o;
  logic [7:0]  len_o;
  logic [7:0]  beat_o;
  logic        first_o;
  logic        last_o;
  logic        err_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bp_me_axi_burst_gen dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .axid_i(axid_i), .axaddr_i(axaddr_i), .axburst_i(axburst_i),
    .axlen_i(axlen_i), .axsize_i(axsize_i), .v_o(v_o), .yumi_i(yumi_i),
    .id_o(id_o), .addr_o(addr_o), .mask_o(mask_o), .size_o(size_o),
    .len_o(len_o), .beat_o(beat_o), .first_o(first_o), .last_o(last_o),
    .err_o(err_o)
  );

  typedef struct {
    logic [1:0]       burst;
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [5:0]       id;
    logic             err;
    logic [3:0][63:0] ea;
    logic [3:0][7:0]  em;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] b, input logic [63:0] a,
                              input logic [7:0] l, input logic [2:0] s,
                              input logic [5:0] id, input logic e,
                              input logic [63:0] a0, a1, a2, a3,
                              input logic [7:0] m0, m1, m2, m3);
    vec_t v;
    v.burst = b; v.addr = a; v.len = l; v.size = s; v.id = id; v.err = e;
    v.ea = {a3, a2, a1, a0};
    v.em = {m3, m2, m1, m0};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] b, input logic [63:0] a,
                       input logic [7:0] l, input logic [2:0] s, input logic [5:0] id);
    v_i = 1'b1; axburst_i = b; axaddr_i = a; axlen_i = l; axsize_i = s; axid_i = id;
  endtask

  // Offer a descriptor until accepted, with a bounded wait.
  task automatic send(input logic [1:0] b, input logic [63:0] a,
                      input logic [7:0] l, input logic [2:0] s, input logic [5:0] id);
    int w;
    drive(b, a, l, s, id);
    w = 0;
    while (!ready_and_o && w < 20) begin
      tick();
      w++;
    end
    if (!ready_and_o) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: got ready 0, want 1");
    end
    tick();
    v_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    axid_i = '0; axaddr_i = '0; axburst_i = '0; axlen_i = '0; axsize_i = '0;

    vt[0] = mk(2'd1, 64'h1004, 8'd3, 3'd3, 6'd1, 1'b0,
               64'h1004, 64'h1008, 64'h1010, 64'h1018, 8'hF0, 8'hFF, 8'hFF, 8'hFF);
    vt[1] = mk(2'd2, 64'h38, 8'd3, 3'd3, 6'd2, 1'b0,
               64'h38, 64'h20, 64'h28, 64'h30, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    vt[2] = mk(2'd0, 64'h102, 8'd2, 3'd1, 6'd3, 1'b0,
               64'h102, 64'h102, 64'h102, 64'h0, 8'h0C, 8'h0C, 8'h0C, 8'h00);
    vt[3] = mk(2'd2, 64'h40, 8'd2, 3'd3, 6'd4, 1'b1,
               64'h40, 64'h48, 64'h50, 64'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[4] = mk(2'd1, 64'hFF8, 8'd1, 3'd3, 6'd5, 1'b1,
               64'hFF8, 64'h1000, 64'h0, 64'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[5] = mk(2'd1, 64'h100, 8'd1, 3'd4, 6'd6, 1'b1,
               64'h100, 64'h110, 64'h0, 64'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[6] = mk(2'd1, 64'h3, 8'd1, 3'd0, 6'd7, 1'b0,
               64'h3, 64'h4, 64'h0, 64'h0, 8'h08, 8'h10, 8'h00, 8'h00);
    vt[7] = mk(2'd2, 64'h14, 8'd1, 3'd2, 6'd8, 1'b0,
               64'h14, 64'h10, 64'h0, 64'h0, 8'hF0, 8'h0F, 8'h00, 8'h00);

    tick(); tick();
    reset_i = 1'b0;
    tick();
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_ready", 64'(ready_and_o), 64'd1);

    // Table of single bursts, consumed one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      send(vt[i].burst, vt[i].addr, vt[i].len, vt[i].size, vt[i].id);
      for (int b = 0; b <= int'(vt[i].len); b++) begin
        chk($sformatf("v%0d_b%0d_v_o", i, b), 64'(v_o), 64'd1);
        chk($sformatf("v%0d_b%0d_addr", i, b), addr_o, vt[i].ea[b]);
        chk($sformatf("v%0d_b%0d_mask", i, b), 64'(mask_o), 64'(vt[i].em[b]));
        chk($sformatf("v%0d_b%0d_beat", i, b), 64'(beat_o), 64'(b));
        chk($sformatf("v%0d_b%0d_first", i, b), 64'(first_o), 64'(b == 0));
        chk($sformatf("v%0d_b%0d_last", i, b), 64'(last_o), 64'(b == int'(vt[i].len)));
        chk($sformatf("v%0d_b%0d_err", i, b), 64'(err_o), 64'(vt[i].err));
        chk($sformatf("v%0d_b%0d_id", i, b), 64'(id_o), 64'(vt[i].id));
        chk($sformatf("v%0d_b%0d_len", i, b), 64'(len_o), 64'(vt[i].len));
        chk($sformatf("v%0d_b%0d_size", i, b), 64'(size_o), 64'(vt[i].size));
        if (b > 0) begin
          yumi_i = 1'b0;
          tick();
          chk($sformatf("v%0d_b%0d_hold", i, b), addr_o, vt[i].ea[b]);
        end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
      end
      chk($sformatf("v%0d_drained", i), 64'(v_o), 64'd0);
    end

    // Two queued bursts back to back; third offer sees a full queue.
    drive(2'd1, 64'h0, 8'd1, 3'd3, 6'd5);
    tick();
    drive(2'd1, 64'h100, 8'd0, 3'd3, 6'd9);
    yumi_i = 1'b1;
    chk("b2b_c0_v", 64'(v_o), 64'd1);
    chk("b2b_c0_id", 64'(id_o), 64'd5);
    chk("b2b_c0_beat", 64'(beat_o), 64'd0);
    tick();
    chk("b2b_c1_v", 64'(v_o), 64'd1);
    chk("b2b_c1_id", 64'(id_o), 64'd5);
    chk("b2b_c1_addr", addr_o, 64'h8);
    chk("b2b_c1_last", 64'(last_o), 64'd1);
    chk("b2b_full", 64'(ready_and_o), 64'd0);
    drive(2'd1, 64'h300, 8'd0, 3'd3, 6'd11);
    tick();
    v_i = 1'b0;
    chk("b2b_c2_v", 64'(v_o), 64'd1);
    chk("b2b_c2_id", 64'(id_o), 64'd9);
    chk("b2b_c2_addr", addr_o, 64'h100);
    chk("b2b_c2_first", 64'(first_o), 64'd1);
    chk("b2b_c2_last", 64'(last_o), 64'd1);
    tick();
    yumi_i = 1'b0;
    chk("b2b_done_v", 64'(v_o), 64'd0);
    chk("b2b_done_ready", 64'(ready_and_o), 64'd1);

    // Accept in the same cycle as the final yumi of a lone burst.
    send(2'd1, 64'h80, 8'd0, 3'd3, 6'd7);
    chk("same_v", 64'(v_o), 64'd1);
    drive(2'd1, 64'h200, 8'd0, 3'd3, 6'd8);
    yumi_i = 1'b1;
    tick();
    v_i = 1'b0;
    chk("same_next_v", 64'(v_o), 64'd1);
    chk("same_next_id", 64'(id_o), 64'd8);
    chk("same_next_addr", addr_o, 64'h200);
    chk("same_next_beat", 64'(beat_o), 64'd0);
    tick();
    yumi_i = 1'b0;
    chk("same_done", 64'(v_o), 64'd0);

    // Reset in the middle of a long burst discards it.
    send(2'd1, 64'h0, 8'd7, 3'd3, 6'd12);
    yumi_i = 1'b1;
    tick();
    tick();
    yumi_i = 1'b0;
    chk("mid_beat", 64'(beat_o), 64'd2);
    chk("mid_addr", addr_o, 64'h10);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mid_rst_v", 64'(v_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_and_o), 64'd1);
    send(2'd1, 64'h88, 8'd0, 3'd3, 6'd13);
    chk("post_rst_v", 64'(v_o), 64'd1);
    chk("post_rst_beat", 64'(beat_o), 64'd0);
    chk("post_rst_addr", addr_o, 64'h88);
    chk("post_rst_id", 64'(id_o), 64'd13);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk("post_rst_done", 64'(v_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
